prog_loader: RTL and testbench

- Serial boot loader that writes the CPU's 256-word, 16-bit program memory; the CPU fetches from that memory.
- Receives a framed image on a UART line (8N1, LSB first).
- Emits one word write per received instruction.
- Holds the CPU in reset until the image is complete and the checksum matches.

---
 rtl/prog_loader.sv | 193 +++++++++++++++++++
 tb/tb_prog_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Serial boot loader: receives a framed program image over an 8N1 UART line,
// writes it into the CPU program memory and releases the CPU on a good checksum.
module prog_loader #(
    parameter int CLKS_PER_BIT  = 16,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        RXD,
    output logic [7:0]  PADDR,
    output logic [15:0] PDATA,
    output logic        PWE,
    output logic        CPU_nRESET,
    output logic        BUSY,
    output logic        ERR
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_BITS  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [2:0] HUNT    = 3'd0;
    localparam logic [2:0] COUNT   = 3'd1;
    localparam logic [2:0] DATA_HI = 3'd2;
    localparam logic [2:0] DATA_LO = 3'd3;
    localparam logic [2:0] CSUM    = 3'd4;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    logic          rx_meta;
    logic          rx_sync;
    logic [1:0]    rx_state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          brk;
    logic          byte_valid;
    logic          frame_err;

    logic [2:0]    f_state;
    logic [7:0]    n_words;
    logic [7:0]    idx;
    logic [7:0]    hi;
    logic [7:0]    acc;

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rx_sync <= rx_meta;
        end
    end

    // Byte receiver: sample mid-bit, timing anchored on the half-bit start check.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            rx_state   <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'h00;
            brk        <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= R_START;
                        cnt      <= '0;
                    end
                end
                R_START: begin
                    if (cnt == HALF_M1) begin
                        cnt      <= '0;
                        bit_idx  <= 3'd0;
                        rx_state <= rx_sync ? R_IDLE : R_BITS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_BITS: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= R_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    // After a bad stop bit, hold here until the line returns idle.
                    if (brk) begin
                        if (rx_sync) begin
                            brk      <= 1'b0;
                            rx_state <= R_IDLE;
                        end
                    end else if (cnt == LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            rx_state   <= R_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            brk       <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            f_state    <= HUNT;
            n_words    <= 8'h00;
            idx        <= 8'h00;
            hi         <= 8'h00;
            acc        <= 8'h00;
            PADDR      <= 8'h00;
            PDATA      <= 16'h0000;
            PWE        <= 1'b0;
            BUSY       <= 1'b0;
            ERR        <= 1'b0;
            CPU_nRESET <= ~HOLD_AT_RESET;
        end else begin
            PWE <= 1'b0;
            if (frame_err) begin
                ERR <= 1'b1;
                if (BUSY) begin
                    BUSY    <= 1'b0;
                    f_state <= HUNT;
                end
            end else if (byte_valid) begin
                case (f_state)
                    HUNT: begin
                        if (shreg == SYNC_BYTE) begin
                            f_state    <= COUNT;
                            BUSY       <= 1'b1;
                            ERR        <= 1'b0;
                            CPU_nRESET <= 1'b0;
                            acc        <= 8'h00;
                            idx        <= 8'h00;
                        end
                    end
                    COUNT: begin
                        n_words <= shreg;
                        f_state <= DATA_HI;
                    end
                    DATA_HI: begin
                        hi      <= shreg;
                        acc     <= acc + shreg;
                        f_state <= DATA_LO;
                    end
                    DATA_LO: begin
                        acc   <= acc + shreg;
                        PDATA <= {hi, shreg};
                        PADDR <= idx;
                        PWE   <= 1'b1;
                        idx   <= idx + 8'd1;
                        // A count of 0 wraps to 255 here, giving a 256-word image.
                        f_state <= (idx == n_words - 8'd1) ? CSUM : DATA_HI;
                    end
                    CSUM: begin
                        BUSY    <= 1'b0;
                        f_state <= HUNT;
                        if (shreg == acc) begin
                            CPU_nRESET <= 1'b1;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                    default: f_state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: UART frame driver, write scoreboard and a
// single check task feeding the final report.
module tb_prog_loader;

    localparam int CPB = 4;

    logic        CLK;
    logic        nRESET;
    logic        RXD;
    logic [7:0]  PADDR;
    logic [15:0] PDATA;
    logic        PWE;
    logic        CPU_nRESET;
    logic        BUSY;
    logic        ERR;

    int vec_cnt;
    int miscompares;
    int wr_cnt;
    logic pwe_prev;
    logic [23:0] exp_q[$];
    logic [15:0] words [256];

    prog_loader #(
        .CLKS_PER_BIT (CPB),
        .HOLD_AT_RESET(1'b1)
    ) dut (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .RXD       (RXD),
        .PADDR     (PADDR),
        .PDATA     (PDATA),
        .PWE       (PWE),
        .CPU_nRESET(CPU_nRESET),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic uart_tx(input logic [7:0] b, input logic stop);
        RXD = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            wait_clks(CPB);
        end
        RXD = stop;
        wait_clks(CPB);
        if (!stop) begin
            RXD = 1'b1;
            wait_clks(CPB);
        end
    endtask

    // Count byte, words[0..n-1] and a checksum offset by delta (0 = good).
    task automatic send_body(input int n, input logic [7:0] delta);
        logic [7:0] sum;
        logic [7:0] cnt_b;
        sum   = 8'h00;
        cnt_b = n[7:0];
        uart_tx(cnt_b, 1'b1);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({i[7:0], words[i]});
            uart_tx(words[i][15:8], 1'b1);
            uart_tx(words[i][7:0], 1'b1);
            sum = sum + words[i][15:8] + words[i][7:0];
        end
        uart_tx(sum + delta, 1'b1);
    endtask

    // Scoreboard: every write strobe must match the next expected write.
    always @(negedge CLK) begin
        if (nRESET && PWE) begin
            wr_cnt++;
            check("pwe_single_cycle", {31'd0, pwe_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                check("pwe_unexpected", {8'h00, PADDR, PDATA}, 32'hFFFF_FFFF);
            end else begin
                check("pwe_write", {8'h00, PADDR, PDATA}, {8'h00, exp_q.pop_front()});
            end
        end
        pwe_prev = PWE;
    end

    initial begin
        vec_cnt     = 0;
        miscompares = 0;
        wr_cnt      = 0;
        pwe_prev    = 1'b0;
        nRESET      = 1'b0;
        RXD         = 1'b1;
        wait_clks(5);
        nRESET = 1'b1;

        // Reset state and idle line
        check("rst_cpu_nreset", {31'd0, CPU_nRESET}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_err", {31'd0, ERR}, 32'd0);
        check("rst_paddr_pdata", {8'h00, PADDR, PDATA}, 32'd0);
        wait_clks(100);
        check("idle_cpu_nreset", {31'd0, CPU_nRESET}, 32'd0);
        check("idle_busy", {31'd0, BUSY}, 32'd0);
        check("idle_writes", wr_cnt, 32'd0);

        // Good two-word frame
        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        uart_tx(8'hA5, 1'b1);
        wait_clks(2);
        check("sync_busy", {31'd0, BUSY}, 32'd1);
        send_body(2, 8'h00);
        check("csum_cpu_still_held", {31'd0, CPU_nRESET}, 32'd0);
        wait_clks(3);
        check("good_cpu_nreset", {31'd0, CPU_nRESET}, 32'd1);
        check("good_err", {31'd0, ERR}, 32'd0);
        check("good_busy", {31'd0, BUSY}, 32'd0);
        check("good_writes", wr_cnt, 32'd2);

        // Bad checksum, then the corrected frame
        uart_tx(8'hA5, 1'b1);
        send_body(2, 8'h01);
        wait_clks(3);
        check("bad_err", {31'd0, ERR}, 32'd1);
        check("bad_cpu_nreset", {31'd0, CPU_nRESET}, 32'd0);
        check("bad_busy", {31'd0, BUSY}, 32'd0);
        check("bad_writes", wr_cnt, 32'd4);
        uart_tx(8'hA5, 1'b1);
        wait_clks(3);
        check("resync_err_clear", {31'd0, ERR}, 32'd0);
        check("resync_busy", {31'd0, BUSY}, 32'd1);
        send_body(2, 8'h00);
        wait_clks(3);
        check("reload_cpu_nreset", {31'd0, CPU_nRESET}, 32'd1);
        check("reload_err", {31'd0, ERR}, 32'd0);

        // One-cycle glitch while hunting
        RXD = 1'b0;
        wait_clks(1);
        RXD = 1'b1;
        wait_clks(60);
        check("glitch_busy", {31'd0, BUSY}, 32'd0);
        check("glitch_cpu_nreset", {31'd0, CPU_nRESET}, 32'd1);
        check("glitch_err", {31'd0, ERR}, 32'd0);
        check("glitch_writes", wr_cnt, 32'd6);

        // Framing error in DATA_HI aborts the frame
        uart_tx(8'hA5, 1'b1);
        uart_tx(8'h02, 1'b1);
        uart_tx(8'h77, 1'b0);
        wait_clks(3);
        check("ferr_err", {31'd0, ERR}, 32'd1);
        check("ferr_busy", {31'd0, BUSY}, 32'd0);
        check("ferr_cpu_nreset", {31'd0, CPU_nRESET}, 32'd0);
        uart_tx(8'h12, 1'b1);
        uart_tx(8'h34, 1'b1);
        wait_clks(3);
        check("ferr_hunt_busy", {31'd0, BUSY}, 32'd0);
        check("ferr_hunt_writes", wr_cnt, 32'd6);

        // Sync byte as data; then a non-sync byte and a sync while running
        words[0] = 16'hA5A5;
        uart_tx(8'hA5, 1'b1);
        send_body(1, 8'h00);
        wait_clks(3);
        check("a5data_cpu_nreset", {31'd0, CPU_nRESET}, 32'd1);
        check("a5data_err", {31'd0, ERR}, 32'd0);
        uart_tx(8'h55, 1'b1);
        wait_clks(3);
        check("run_55_busy", {31'd0, BUSY}, 32'd0);
        check("run_55_cpu_nreset", {31'd0, CPU_nRESET}, 32'd1);
        uart_tx(8'hA5, 1'b1);
        wait_clks(3);
        check("run_a5_cpu_nreset", {31'd0, CPU_nRESET}, 32'd0);
        check("run_a5_busy", {31'd0, BUSY}, 32'd1);
        words[0] = 16'h0F0F;
        send_body(1, 8'h00);
        wait_clks(3);
        check("run_reload_cpu_nreset", {31'd0, CPU_nRESET}, 32'd1);

        // Full 256-word image (count byte 00)
        for (int i = 0; i < 256; i++) words[i] = i[15:0] * 16'h0101;
        uart_tx(8'hA5, 1'b1);
        send_body(256, 8'h00);
        wait_clks(3);
        check("full_cpu_nreset", {31'd0, CPU_nRESET}, 32'd1);
        check("full_busy", {31'd0, BUSY}, 32'd0);
        check("full_err", {31'd0, ERR}, 32'd0);
        check("full_writes", wr_cnt, 32'd264);
        check("full_queue_empty", exp_q.size(), 32'd0);
        check("full_hold_last", {8'h00, PADDR, PDATA}, 32'h00FF_FFFF);

        // Reset mid-frame; trailing bytes land in HUNT and are ignored
        uart_tx(8'hA5, 1'b1);
        uart_tx(8'h01, 1'b1);
        uart_tx(8'h12, 1'b1);
        nRESET = 1'b0;
        wait_clks(2);
        nRESET = 1'b1;
        wait_clks(1);
        check("midrst_paddr_pdata", {8'h00, PADDR, PDATA}, 32'd0);
        check("midrst_busy", {31'd0, BUSY}, 32'd0);
        check("midrst_cpu_nreset", {31'd0, CPU_nRESET}, 32'd0);
        check("midrst_err", {31'd0, ERR}, 32'd0);
        uart_tx(8'h34, 1'b1);
        uart_tx(8'h46, 1'b1);
        wait_clks(3);
        check("midrst_no_write", wr_cnt, 32'd264);
        check("midrst_hunt_busy", {31'd0, BUSY}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
